// File: rtl/riscv_div_unit.sv
// Multi-cycle radix-2 restoring divider for RISC-V DIV/DIVU/REM/REMU with sign fix-up.
// Optional DIV_EARLY_OUT_EN: finishes in one cycle when |a| < |b|.
module riscv_div_unit #(
    parameter int DATA_W = 32,
    parameter int ALU_OP = 5,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ALU_OP-1:0] req_op,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    input  logic [ADDR_W-1:0] req_rd,
    input  logic              flush,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic [ADDR_W-1:0] resp_rd,
    output logic              resp_illegal,
    output logic              busy
);

    localparam logic [ALU_OP-1:0] ALU_DIV  = ALU_OP'(5'b01100);
    localparam logic [ALU_OP-1:0] ALU_DIVU = ALU_OP'(5'b01101);
    localparam logic [ALU_OP-1:0] ALU_REM  = ALU_OP'(5'b01010);
    localparam logic [ALU_OP-1:0] ALU_REMU = ALU_OP'(5'b01011);
    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;
    state_t state, state_next;

    logic [DATA_W-1:0] divisor, quo, rem;
    logic [CNT_W-1:0]  count;
    logic              q_neg, r_neg, want_rem;

    logic              op_legal, op_signed, op_rem, a_neg, b_neg;
    logic              b_zero, overflow, early_out, special, accept;
    logic [DATA_W-1:0] a_mag, b_mag, special_data;
    logic [DATA_W:0]   shifted, trial;
    logic              take;
    logic [DATA_W-1:0] q_final, r_final;

    // Request decode: magnitudes and the results that skip the iterative loop
    always_comb begin
        op_legal  = (req_op == ALU_DIV) || (req_op == ALU_DIVU) ||
                    (req_op == ALU_REM) || (req_op == ALU_REMU);
        op_signed = (req_op == ALU_DIV) || (req_op == ALU_REM);
        op_rem    = (req_op == ALU_REM) || (req_op == ALU_REMU);
        a_neg     = op_signed & req_a[DATA_W-1];
        b_neg     = op_signed & req_b[DATA_W-1];
        a_mag     = a_neg ? -req_a : req_a;
        b_mag     = b_neg ? -req_b : req_b;
        b_zero    = (req_b == '0);
        overflow  = op_signed && (req_a == MIN_NEG) && (req_b == '1);
`ifdef DIV_EARLY_OUT_EN
        early_out = !b_zero && (a_mag < b_mag);
`else
        early_out = 1'b0;
`endif
        special      = !op_legal || b_zero || overflow || early_out;
        special_data = '0;
        if (!op_legal)
            special_data = '0;
        else if (b_zero)
            special_data = op_rem ? req_a : '1;
        else if (overflow)
            special_data = op_rem ? '0 : MIN_NEG;
        else if (early_out)
            special_data = op_rem ? req_a : '0;
        accept = (state == IDLE) && req_valid && !flush;
    end

    // A set MSB in the shifted remainder means it already exceeds any divisor
    always_comb begin
        shifted = {rem, quo[DATA_W-1]};
        trial   = shifted - {1'b0, divisor};
        take    = shifted[DATA_W] | ~trial[DATA_W];
        q_final = q_neg ? -quo : quo;
        r_final = r_neg ? -rem : rem;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = special ? DONE : CALC;
            CALC: if (count == '0) state_next = SIGN;
            SIGN: state_next = DONE;
            DONE: if (resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush && (state != IDLE))
            state_next = IDLE;
    end

    assign req_ready  = (state == IDLE);
    assign busy       = (state != IDLE);
    assign resp_valid = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_data    <= '0;
            resp_rd      <= '0;
            resp_illegal <= 1'b0;
            quo          <= '0;
            rem          <= '0;
            divisor      <= '0;
            count        <= '0;
            q_neg        <= 1'b0;
            r_neg        <= 1'b0;
            want_rem     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        resp_rd      <= req_rd;
                        resp_illegal <= !op_legal;
                        quo          <= a_mag;
                        rem          <= '0;
                        divisor      <= b_mag;
                        count        <= CNT_W'(DATA_W - 1);
                        q_neg        <= a_neg ^ b_neg;
                        r_neg        <= a_neg;
                        want_rem     <= op_rem;
                        if (special)
                            resp_data <= special_data;
                    end
                end
                CALC: begin
                    quo   <= {quo[DATA_W-2:0], take};
                    rem   <= take ? trial[DATA_W-1:0] : shifted[DATA_W-1:0];
                    count <= count - CNT_W'(1);
                end
                SIGN: resp_data <= want_rem ? r_final : q_final;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_div_unit.sv
// Self-checking bench for riscv_div_unit: directed corner cases, flush/reset, randomized ops.
// Honours DIV_EARLY_OUT_EN for expected latencies.
module tb_riscv_div_unit;

    localparam logic [4:0] OP_DIV  = 5'b01100;
    localparam logic [4:0] OP_DIVU = 5'b01101;
    localparam logic [4:0] OP_REM  = 5'b01010;
    localparam logic [4:0] OP_REMU = 5'b01011;
    localparam logic [4:0] OP_ADD  = 5'b00010;
    localparam int NORMAL_LAT = 34;
`ifdef DIV_EARLY_OUT_EN
    localparam int EARLY_LAT = 1;
`else
    localparam int EARLY_LAT = NORMAL_LAT;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [4:0]  req_op;
    logic [31:0] req_a, req_b;
    logic [4:0]  req_rd;
    logic        flush;
    logic        resp_valid, resp_ready;
    logic [31:0] resp_data;
    logic [4:0]  resp_rd;
    logic        resp_illegal;
    logic        busy;

    int checks = 0;
    int failures = 0;
    bit started = 0;
    bit exp_outstanding = 0;
    logic [31:0] exp_data;
    logic [4:0]  exp_rd;
    logic        exp_illegal;

    riscv_div_unit #(.DATA_W(32), .ALU_OP(5), .ADDR_W(5)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_rd(req_rd),
        .flush(flush),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_rd(resp_rd), .resp_illegal(resp_illegal), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    function automatic bit is_legal(input logic [4:0] op);
        return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
    endfunction

    // Reference results straight from the RISC-V M-extension rules
    function automatic logic [31:0] model_data(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        sa = a;
        sb = b;
        case (op)
            OP_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            OP_REMU: return (b == 0) ? a : a % b;
            OP_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return sa / sb;
            end
            OP_REM: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return sa % sb;
            end
            default: return 32'h0;
        endcase
    endfunction

    function automatic int model_latency(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        bit sgn;
        logic [31:0] ma, mb;
        if (!is_legal(op) || b == 0) return 1;
        sgn = (op == OP_DIV) || (op == OP_REM);
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        ma = (sgn && a[31]) ? 32'(0 - a) : a;
        mb = (sgn && b[31]) ? 32'(0 - b) : b;
        if (ma < mb) return EARLY_LAT;
        return NORMAL_LAT;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Compare process: whenever a response is outstanding and valid, it must match
    always @(negedge clk) begin
        if (started && !rst) begin
            if (exp_outstanding) begin
                if (resp_valid) begin
                    checkOutput("resp_data", resp_data, exp_data);
                    checkOutput("resp_rd", 32'(resp_rd), 32'(exp_rd));
                    checkOutput("resp_illegal", 32'(resp_illegal), 32'(exp_illegal));
                end
            end else begin
                checkOutput("no_spurious_valid", 32'(resp_valid), 32'h0);
            end
        end
    end

    task automatic doReset();
        rst = 1'b1;
        exp_outstanding = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic applyStimulus(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] rd, input logic [31:0] e_data, input logic e_ill,
                                 input int e_lat, input int hold);
        int lat;
        @(negedge clk);
        checkOutput("req_ready_idle", 32'(req_ready), 32'h1);
        req_valid = 1'b1;
        req_op = op;
        req_a = a;
        req_b = b;
        req_rd = rd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op = 5'($urandom);
        req_a = $urandom;
        req_b = $urandom;
        req_rd = 5'($urandom);
        exp_data = e_data;
        exp_rd = rd;
        exp_illegal = e_ill;
        exp_outstanding = 1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!resp_valid && lat < 100);
        checkOutput("latency", 32'(lat), 32'(e_lat));
        if (!resp_valid) begin
            doReset();
            return;
        end
        for (int i = 0; i < hold; i++) begin
            checkOutput("ready_low_in_done", 32'(req_ready), 32'h0);
            checkOutput("busy_in_done", 32'(busy), 32'h1);
            checkOutput("valid_held", 32'(resp_valid), 32'h1);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        exp_outstanding = 0;
    endtask

    initial begin
        logic [4:0] op;
        logic [31:0] a, b;
        int r;
        rst = 1'b1;
        req_valid = 1'b0;
        req_op = '0;
        req_a = '0;
        req_b = '0;
        req_rd = '0;
        flush = 1'b0;
        resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_req_ready", 32'(req_ready), 32'h1);
        checkOutput("reset_resp_valid", 32'(resp_valid), 32'h0);
        checkOutput("reset_busy", 32'(busy), 32'h0);
        checkOutput("reset_resp_data", resp_data, 32'h0);
        checkOutput("reset_resp_rd", 32'(resp_rd), 32'h0);
        checkOutput("reset_resp_illegal", 32'(resp_illegal), 32'h0);
        started = 1;

        applyStimulus(OP_DIVU, 32'd100, 32'd7, 5'd1, 32'd14, 1'b0, 34, 0);
        applyStimulus(OP_REMU, 32'd100, 32'd7, 5'd2, 32'd2, 1'b0, 34, 0);
        applyStimulus(OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd3, 32'hFFFF_FFFD, 1'b0, 34, 1);
        applyStimulus(OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFF, 1'b0, 34, 0);
        applyStimulus(OP_REM, 32'd7, 32'hFFFF_FFFE, 5'd5, 32'd1, 1'b0, 34, 0);
        applyStimulus(OP_DIV, 32'd5, 32'd0, 5'd6, 32'hFFFF_FFFF, 1'b0, 1, 0);
        applyStimulus(OP_REMU, 32'd5, 32'd0, 5'd7, 32'd5, 1'b0, 1, 0);
        applyStimulus(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'h8000_0000, 1'b0, 1, 0);
        applyStimulus(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 32'h0, 1'b0, 1, 0);
        applyStimulus(OP_ADD, 32'd3, 32'd4, 5'd10, 32'h0, 1'b1, 1, 0);
        applyStimulus(OP_DIVU, 32'd3, 32'd10, 5'd11, 32'h0, 1'b0, EARLY_LAT, 0);
        applyStimulus(OP_DIVU, 32'd1000, 32'd9, 5'd12, 32'd111, 1'b0, 34, 10);
        applyStimulus(OP_REMU, 32'd1000, 32'd9, 5'd13, 32'd1, 1'b0, 34, 0);

        // Flush ten cycles into CALC
        @(negedge clk);
        req_valid = 1'b1; req_op = OP_DIVU; req_a = 32'd100; req_b = 32'd7; req_rd = 5'd20;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("busy_mid_calc", 32'(busy), 32'h1);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        checkOutput("flush_busy", 32'(busy), 32'h0);
        checkOutput("flush_resp_valid", 32'(resp_valid), 32'h0);
        checkOutput("flush_req_ready", 32'(req_ready), 32'h1);
        repeat (40) @(negedge clk);

        // Flush in IDLE wins over a simultaneous request
        req_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1 begin req_valid = 1'b0; flush = 1'b0; end
        @(negedge clk);
        checkOutput("flush_idle_busy", 32'(busy), 32'h0);
        checkOutput("flush_idle_ready", 32'(req_ready), 32'h1);
        repeat (3) @(negedge clk);

        // Reset mid-CALC
        req_valid = 1'b1; req_op = OP_DIV; req_a = 32'h1234_5678; req_b = 32'd3; req_rd = 5'd21;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_mid_req_ready", 32'(req_ready), 32'h1);
        checkOutput("rst_mid_resp_valid", 32'(resp_valid), 32'h0);
        checkOutput("rst_mid_busy", 32'(busy), 32'h0);
        checkOutput("rst_mid_resp_data", resp_data, 32'h0);
        checkOutput("rst_mid_resp_rd", 32'(resp_rd), 32'h0);
        checkOutput("rst_mid_resp_illegal", 32'(resp_illegal), 32'h0);

        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 8);
            case (r)
                0, 1: op = OP_DIV;
                2, 3: op = OP_DIVU;
                4, 5: op = OP_REM;
                6, 7: op = OP_REMU;
                default: begin
                    do op = 5'($urandom); while (is_legal(op));
                end
            endcase
            a = pick_operand();
            b = pick_operand();
            applyStimulus(op, a, b, 5'($urandom), model_data(op, a, b), !is_legal(op),
                          model_latency(op, a, b), $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
